// File: rtl/udp_cmd_reply_tx.sv
// udp_cmd_reply_tx
//   Serialises one command reply descriptor into the UDP reply payload:
//   SEQ | MSG_ID | ADDR | [DATA]. Every field is sent MSB first. DATA is
//   appended only for a read ACK. A downstream stall that lasts
//   STALL_TIMEOUT_CLKS cycles drops the partial reply and pulses o_tx_abort.
//   Optional feature: define UDP_CMD_REPLY_STATS_EN to add saturating
//   ack/nack/abort counters (o_ack_cnt, o_nack_cnt, o_abort_cnt).
module udp_cmd_reply_tx #(
  parameter int SEQ_BYTES          = 4,
  parameter int ADDR_BYTES         = 4,
  parameter int DATA_BYTES         = 4,
  parameter int STALL_TIMEOUT_CLKS = 512
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [8*SEQ_BYTES-1:0]  i_req_seq,
  input  logic [7:0]              i_req_msg_id,
  input  logic                    i_req_is_read,
  input  logic [8*ADDR_BYTES-1:0] i_req_addr,
  input  logic [8*DATA_BYTES-1:0] i_req_data,
  output logic [7:0]              o_tx_byte,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_tx_last,
  output logic                    o_tx_abort
`ifdef UDP_CMD_REPLY_STATS_EN
  ,
  output logic [15:0]             o_ack_cnt,
  output logic [15:0]             o_nack_cnt,
  output logic [15:0]             o_abort_cnt
`endif
);

  localparam int SEQ_W  = 8 * SEQ_BYTES;
  localparam int ADDR_W = 8 * ADDR_BYTES;
  localparam int DATA_W = 8 * DATA_BYTES;

  localparam logic [7:0] MSG_ACK     = 8'hF0;
  localparam logic [7:0] MSG_NACK    = 8'hF1;
  localparam logic [7:0] MSG_UNKNOWN = 8'hFF;

  // The byte counter must hold the largest field index.
  localparam int MAX_SA    = (SEQ_BYTES > ADDR_BYTES) ? SEQ_BYTES : ADDR_BYTES;
  localparam int MAX_BYTES = (MAX_SA > DATA_BYTES) ? MAX_SA : DATA_BYTES;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);
  localparam int STALL_W   = $clog2(STALL_TIMEOUT_CLKS + 1);

  localparam logic [CNT_W-1:0]   SEQ_FIRST  = CNT_W'(SEQ_BYTES - 1);
  localparam logic [CNT_W-1:0]   ADDR_FIRST = CNT_W'(ADDR_BYTES - 1);
  localparam logic [CNT_W-1:0]   DATA_FIRST = CNT_W'(DATA_BYTES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEQ,
    S_MSGID,
    S_ADDR,
    S_DATA
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;          // bytes still to send in the field, minus one
  logic [SEQ_W-1:0]    seq_q, seq_d;          // shifted left as bytes leave; MSB is current byte
  logic [7:0]          msg_q, msg_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                send_data_q, send_data_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic                abort_q, abort_d;

  logic [7:0]          msg_coerced;
  logic                tx_hs;
  logic                final_byte;
  logic                stall_hit;

  // Any message id outside ACK/NACK is reported as UNKNOWN.
  always_comb begin
    msg_coerced = MSG_UNKNOWN;
    if ((i_req_msg_id == MSG_ACK) || (i_req_msg_id == MSG_NACK)) begin
      msg_coerced = i_req_msg_id;
    end
  end

  assign o_req_ready = (state_q == S_IDLE);
  assign o_tx_valid  = (state_q != S_IDLE);
  assign tx_hs       = o_tx_valid && i_tx_ready;
  assign final_byte  = (cnt_q == '0) &&
                       (((state_q == S_ADDR) && !send_data_q) || (state_q == S_DATA));
  assign o_tx_last   = final_byte;
  assign o_tx_abort  = abort_q;
  // The 512th consecutive stalled cycle ends the reply.
  assign stall_hit   = o_tx_valid && !i_tx_ready && (stall_q == STALL_LAST);

  // Current payload byte: the top byte of the active field's shift register.
  always_comb begin
    o_tx_byte = 8'h00;
    case (state_q)
      S_SEQ:   o_tx_byte = seq_q[SEQ_W-1 -: 8];
      S_MSGID: o_tx_byte = msg_q;
      S_ADDR:  o_tx_byte = addr_q[ADDR_W-1 -: 8];
      S_DATA:  o_tx_byte = data_q[DATA_W-1 -: 8];
      default: o_tx_byte = 8'h00;
    endcase
  end

  // Next-state logic: descriptor capture, field sequencing and stall watchdog.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seq_d       = seq_q;
    msg_d       = msg_q;
    addr_d      = addr_q;
    data_d      = data_q;
    send_data_d = send_data_q;
    abort_d     = 1'b0;

    if (tx_hs || !o_tx_valid) begin
      stall_d = '0;
    end else begin
      stall_d = stall_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          seq_d       = i_req_seq;
          msg_d       = msg_coerced;
          addr_d      = i_req_addr;
          data_d      = i_req_data;
          send_data_d = (msg_coerced == MSG_ACK) && i_req_is_read;
          cnt_d       = SEQ_FIRST;
          state_d     = S_SEQ;
        end
      end

      S_SEQ: begin
        if (tx_hs) begin
          seq_d = seq_q << 8;
          if (cnt_q == '0) begin
            state_d = S_MSGID;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      S_MSGID: begin
        if (tx_hs) begin
          cnt_d   = ADDR_FIRST;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (tx_hs) begin
          addr_d = addr_q << 8;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (send_data_q) begin
            cnt_d   = DATA_FIRST;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (tx_hs) begin
          data_d = data_q << 8;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Downstream stuck: drop the partial reply and flag it for one cycle.
    if (stall_hit) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      stall_d = '0;
      abort_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      seq_q       <= '0;
      msg_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      send_data_q <= 1'b0;
      stall_q     <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seq_q       <= seq_d;
      msg_q       <= msg_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      send_data_q <= send_data_d;
      stall_q     <= stall_d;
      abort_q     <= abort_d;
    end
  end

`ifdef UDP_CMD_REPLY_STATS_EN
  logic [15:0] ack_cnt_q, ack_cnt_d;
  logic [15:0] nack_cnt_q, nack_cnt_d;
  logic [15:0] abort_cnt_q, abort_cnt_d;

  // Saturating reply statistics; UNKNOWN replies count as nack.
  always_comb begin
    ack_cnt_d   = ack_cnt_q;
    nack_cnt_d  = nack_cnt_q;
    abort_cnt_d = abort_cnt_q;
    if (tx_hs && final_byte) begin
      if (msg_q == MSG_ACK) begin
        if (ack_cnt_q != 16'hFFFF) ack_cnt_d = ack_cnt_q + 16'd1;
      end else begin
        if (nack_cnt_q != 16'hFFFF) nack_cnt_d = nack_cnt_q + 16'd1;
      end
    end
    if (abort_q && (abort_cnt_q != 16'hFFFF)) begin
      abort_cnt_d = abort_cnt_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_cnt_q   <= '0;
      nack_cnt_q  <= '0;
      abort_cnt_q <= '0;
    end else begin
      ack_cnt_q   <= ack_cnt_d;
      nack_cnt_q  <= nack_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign o_ack_cnt   = ack_cnt_q;
  assign o_nack_cnt  = nack_cnt_q;
  assign o_abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_udp_cmd_reply_tx.sv
// tb_udp_cmd_reply_tx
//   Scoreboard bench: each request pushes its expected payload bytes to a
//   queue; a monitor pops and compares on every tx handshake and checks
//   that stalled outputs hold stable.
module tb_udp_cmd_reply_tx;

  localparam int         STALL_CLKS = 512;
  localparam logic [7:0] MSG_ACK    = 8'hF0;
  localparam logic [7:0] MSG_NACK   = 8'hF1;
  localparam logic [7:0] MSG_UNK    = 8'hFF;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [31:0] i_req_seq = '0;
  logic [7:0]  i_req_msg_id = '0;
  logic        i_req_is_read = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_data = '0;
  logic [7:0]  o_tx_byte;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b1;
  logic        o_tx_last;
  logic        o_tx_abort;
`ifdef UDP_CMD_REPLY_STATS_EN
  logic [15:0] o_ack_cnt, o_nack_cnt, o_abort_cnt;
`endif

  udp_cmd_reply_tx dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_seq     (i_req_seq),
    .i_req_msg_id  (i_req_msg_id),
    .i_req_is_read (i_req_is_read),
    .i_req_addr    (i_req_addr),
    .i_req_data    (i_req_data),
    .o_tx_byte     (o_tx_byte),
    .o_tx_valid    (o_tx_valid),
    .i_tx_ready    (i_tx_ready),
    .o_tx_last     (o_tx_last),
    .o_tx_abort    (o_tx_abort)
`ifdef UDP_CMD_REPLY_STATS_EN
    ,
    .o_ack_cnt     (o_ack_cnt),
    .o_nack_cnt    (o_nack_cnt),
    .o_abort_cnt   (o_abort_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected stream: {last, byte}
  logic [8:0] exp_q[$];
  int         ready_mode = 0;   // 0: always ready, 1: toggle, 2: stall after 4 bytes
  int         frame_hs = 0;
  int         stall_run = 0;
  int         abort_seen = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte = '0;
  logic       prev_last = 1'b0;
  logic [8:0] mon_e;

  // Reference payload builder.
  task automatic push_reply(input logic [31:0] seq, input logic [7:0] id, input logic rd,
                            input logic [31:0] addr, input logic [31:0] data);
    logic [7:0] m;
    logic       with_data;
    logic       lst;
    logic [7:0] bytes[$];
    m = ((id == MSG_ACK) || (id == MSG_NACK)) ? id : MSG_UNK;
    with_data = (m == MSG_ACK) && rd;
    for (int i = 3; i >= 0; i--) bytes.push_back(seq[8*i +: 8]);
    bytes.push_back(m);
    for (int i = 3; i >= 0; i--) bytes.push_back(addr[8*i +: 8]);
    if (with_data) begin
      for (int i = 3; i >= 0; i--) bytes.push_back(data[8*i +: 8]);
    end
    foreach (bytes[k]) begin
      lst = (k == bytes.size() - 1);
      exp_q.push_back({lst, bytes[k]});
    end
  endtask

  // Downstream ready pattern, updated just after each rising edge.
  always @(posedge i_clk) begin
    #1;
    case (ready_mode)
      0:       i_tx_ready = 1'b1;
      1:       i_tx_ready = ~i_tx_ready;
      default: i_tx_ready = (frame_hs < 4);
    endcase
  end

  // Monitor: compare handshakes against the scoreboard, check stall stability.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      prev_stall = 1'b0;
      stall_run  = 0;
    end else begin
      if (prev_stall && !o_tx_abort) begin
        check("hold_valid", o_tx_valid, 1);
        check("hold_byte", o_tx_byte, prev_byte);
        check("hold_last", o_tx_last, prev_last);
      end
      if (o_tx_abort) begin
        abort_seen++;
        check("abort_stall_len", stall_run, STALL_CLKS);
        check("abort_valid_low", o_tx_valid, 0);
        $display("reply aborted after %0d stalled cycles, %0d bytes dropped", stall_run, exp_q.size());
        exp_q.delete();
        frame_hs  = 0;
        stall_run = 0;
      end
      if (o_tx_valid && i_tx_ready) begin
        stall_run = 0;
        frame_hs++;
        if (exp_q.size() == 0) begin
          check("spurious_byte", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("tx_byte", o_tx_byte, mon_e[7:0]);
          check("tx_last", o_tx_last, mon_e[8]);
          if (mon_e[8]) begin
            $display("reply done: %0d bytes", frame_hs);
            frame_hs = 0;
          end
        end
      end else if (o_tx_valid) begin
        stall_run++;
      end
      prev_stall = o_tx_valid && !i_tx_ready;
      prev_byte  = o_tx_byte;
      prev_last  = o_tx_last;
    end
  end

  // Present one descriptor and hold it until accepted.
  task automatic send_req(input logic [31:0] seq, input logic [7:0] id, input logic rd,
                          input logic [31:0] addr, input logic [31:0] data);
    logic acc;
    push_reply(seq, id, rd, addr, data);
    @(posedge i_clk);
    #1;
    i_req_valid   = 1'b1;
    i_req_seq     = seq;
    i_req_msg_id  = id;
    i_req_is_read = rd;
    i_req_addr    = addr;
    i_req_data    = data;
    acc = 1'b0;
    for (int c = 0; c < 2000 && !acc; c++) begin
      @(negedge i_clk);
      if (o_req_ready) acc = 1'b1;
    end
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    check("req_accepted", acc, 1);
  endtask

  // Count cycles from accept until the last-byte handshake.
  task automatic wait_done(output int cycles);
    logic done;
    done   = 1'b0;
    cycles = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge i_clk);
      cycles++;
      if (o_tx_valid && i_tx_ready && o_tx_last) done = 1'b1;
    end
    check("reply_finished", done, 1);
  endtask

  task automatic check_idle_after(input string tag);
    @(negedge i_clk);
    check({tag, "_ready"}, o_req_ready, 1);
    check({tag, "_valid"}, o_tx_valid, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    logic got_abort;

    repeat (3) @(negedge i_clk);
    check("rst_req_ready", o_req_ready, 1);
    check("rst_tx_valid", o_tx_valid, 0);
    check("rst_tx_last", o_tx_last, 0);
    check("rst_tx_abort", o_tx_abort, 0);
    check("rst_tx_byte", o_tx_byte, 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // NACK write: 9 bytes in 9 cycles
    send_req(32'h0000_0001, MSG_NACK, 1'b0, 32'h0102_0304, 32'h0);
    wait_done(cyc);
    check("nack_cycles", cyc, 9);
    check_idle_after("nack_idle");

    // Read ACK: 13 bytes
    send_req(32'hDEAD_BEEF, MSG_ACK, 1'b1, 32'h0001_0010, 32'hCAFE_F00D);
    wait_done(cyc);
    check("rdack_cycles", cyc, 13);
    check_idle_after("rdack_idle");

    // Write ACK: data suppressed
    send_req(32'h1234_5678, MSG_ACK, 1'b0, 32'hA5A5_5A5A, 32'hFFFF_FFFF);
    wait_done(cyc);
    check("wrack_cycles", cyc, 9);

    // Illegal id coerced to UNKNOWN, even for a read
    send_req(32'h0BAD_F00D, 8'h42, 1'b1, 32'h0000_00FF, 32'h1111_2222);
    wait_done(cyc);
    check("coerce_cycles", cyc, 9);

    // Explicit UNKNOWN read: no data
    send_req(32'h8000_0000, MSG_UNK, 1'b1, 32'hFFFF_0000, 32'h3333_4444);
    wait_done(cyc);
    check("unk_cycles", cyc, 9);

    // Read ACK with ready toggling every cycle
    ready_mode = 1;
    send_req(32'hDEAD_BEEF, MSG_ACK, 1'b1, 32'h0001_0010, 32'hCAFE_F00D);
    wait_done(cyc);
    ready_mode = 0;
    check_idle_after("toggle_idle");

    // Stall timeout after byte 3
    ready_mode = 2;
    send_req(32'h5555_AAAA, MSG_ACK, 1'b1, 32'h0000_0040, 32'h7777_8888);
    got_abort = 1'b0;
    for (int c = 0; c < 2000 && !got_abort; c++) begin
      @(negedge i_clk);
      if (o_tx_abort) got_abort = 1'b1;
    end
    check("abort_pulse_seen", got_abort, 1);
    ready_mode = 0;
    @(negedge i_clk);
    check("abort_one_cycle", o_tx_abort, 0);
    check("abort_then_ready", o_req_ready, 1);
    send_req(32'h0000_0002, MSG_NACK, 1'b0, 32'h0102_0304, 32'h0);
    wait_done(cyc);
    check("post_abort_cycles", cyc, 9);

    // Asynchronous reset while byte 6 is on the bus
    send_req(32'hDEAD_BEEF, MSG_ACK, 1'b1, 32'h0001_0010, 32'hCAFE_F00D);
    repeat (6) @(posedge i_clk);
    #1;
    check("pre_reset_byte6", o_tx_byte, 8'h01);
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", o_tx_valid, 0);
    check("mid_rst_ready", o_req_ready, 1);
    check("mid_rst_last", o_tx_last, 0);
    check("mid_rst_abort", o_tx_abort, 0);
    check("mid_rst_byte", o_tx_byte, 0);
    exp_q.delete();
    frame_hs = 0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    send_req(32'hFEED_0001, MSG_ACK, 1'b1, 32'h0000_0004, 32'h0102_0304);
    wait_done(cyc);
    check("post_rst_cycles", cyc, 13);
    check_idle_after("final_idle");

    check("queue_drained", exp_q.size(), 0);
    check("abort_count", abort_seen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
